keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Column-scan controller for the 4x4 matrix keypad. Drives kpc one column low at a time,
//  samples kpr, debounces, and reports one key code per press. Key code comes from an
//  internal kpdecode instance. Feeds the safe's code-entry logic through a valid/ack handshake.
// PARAMETERS
//  SCAN_DIV    50000  clk cycles per column dwell (1 ms @ 50 MHz); legal range >= 4
//  DEBOUNCE_N  8      consecutive stable dwell samples needed to accept a press or a release
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset_n    in   1  synchronous, active-low reset
//  kpr        in   4  raw keypad rows, active-low, asynchronous to clk
//  kpc        out  4  column drive, one-hot-low
//  key_ack    in   1  consumer acknowledges key_num; clears key_valid and overrun
//  key_valid  out  1  level; high from an accepted press until key_ack
//  key_num    out  4  hex code of the last accepted key; stable while key_valid
//  key_held   out  1  high while the accepted key is still down (HELD state)
//  overrun    out  1  sticky; a press was accepted while key_valid was already high
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    - kpc=4'b1110, key_valid=0, key_num=0, key_held=0, overrun=0.
//    - state=SCAN; dwell and debounce counters = 0; kpr synchroniser flops = 4'b1111.
//  - kpr passes through a 2-flop synchroniser (kpr_s). kpr_s is 2 cycles late, so the
//    requirement SCAN_DIV >= 4 guarantees kpr_s has settled to the current column.
//  - tick: 1-cycle pulse on the last cycle of each dwell (dwell cnt == SCAN_DIV-1, then wraps to 0).
//    Every kpr_s evaluation below happens on tick only.
//  - Decode: kpdecode(kpr_s, kpc) gives kphit and code.
//    - kphit=0 whenever kpr_s is not one-hot-low. This covers no key and multi-row presses.
//  - SCAN:
//    - On tick with kphit=0: kpc rotates 1110->1101->1011->0111->1110.
//    - On tick with kphit=1: latch kpr_s into row_l and freeze kpc. Set deb_cnt=1 and go to DEBOUNCE.
//  - DEBOUNCE (kpc frozen):
//    - On tick with kphit=1 and kpr_s==row_l: deb_cnt++.
//    - Once deb_cnt reaches DEBOUNCE_N, accept the press and go to HELD.
//    - On tick with any mismatch: go to SCAN and rotate kpc. No key is reported.
//  - Accepting a press:
//    - If key_valid=0: key_num<=code and key_valid<=1 on the same edge.
//    - If key_valid=1: key_num is unchanged and overrun<=1.
//  - HELD (kpc frozen, key_held=1):
//    - On tick with kpr_s==4'b1111: rel_cnt++. On tick with any other kpr_s: rel_cnt<=0.
//    - rel_cnt==DEBOUNCE_N: go to SCAN, rotate kpc, key_held<=0. Auto-repeat is not supported.
//  - key_ack:
//    - Sampled every cycle; clears key_valid and overrun on the next edge.
//    - If key_ack and an accept happen on the same edge, the accept wins: key_valid=1 with the
//      new key_num, and overrun=0.
//  - Reset mid-operation (any state) returns to the reset values on that edge. A partially
//    debounced press is discarded.
//  - Keypad map: the column in the low kpc bit and the row in the low kpr bit give key 'd';
//    full table in kpdecode.
//  - Latency: key down to key_valid = 2 sync cycles + DEBOUNCE_N dwell ticks (worst case
//    + 4 dwells to reach the column).
// STRUCTURE
//  - kp_pkg:
//    - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t
//    - localparam COL_FIRST=4'b1110
//    - localparam KP_IDLE=4'b1111
//  - Sub-module: existing kpdecode, instantiated unchanged, combinational.
//  - Synchroniser, dwell counter and FSM stay inline.
// TESTING (SCAN_DIV=4, DEBOUNCE_N=3; keypad model drives kpr from the current kpc)
//  1. Reset low 3 cycles -> kpc=1110, key_valid=0, key_num=0, overrun=0; after release kpc
//     steps 1110,1101,1011,0111,1110, 4 clk each.
//  2. Hold key '5' (row 1011 / col 1011) -> kpc freezes at 1011; key_valid=1 and key_num=4'h5
//     after 3 ticks; key_held=1. Release -> key_held=0 after 3 idle ticks; next kpc=0111.
//  3. Bounce: '5' pressed, kpr=1111 on 2nd debounce tick -> key_valid stays 0; scan resumes
//     at 0111.
//  4. Two rows in one column (kpr=1010) -> kpc keeps rotating; key_valid never asserts.
//  5. Press '1', release, no ack, press 'a' -> key_num stays 4'h1, overrun=1. Pulse key_ack
//     -> key_valid=0, overrun=0.
//  6. reset_n low for 1 cycle during DEBOUNCE -> next cycle kpc=1110, state SCAN, no key_valid.

Source files
------------

// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
package kp_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

  localparam logic [3:0] COL_FIRST = 4'b1110;
  localparam logic [3:0] KP_IDLE   = 4'b1111;

  function automatic logic [3:0] rotate_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/kpdecode.sv
// Combinational key decoder: one-hot-low row and column to hex key code.
module kpdecode (
  input  logic [3:0] kpr,
  input  logic [3:0] kpc,
  output logic       kphit,
  output logic [3:0] code
);
  logic [1:0] w_row;
  logic [1:0] w_col;
  logic       w_row_ok;
  logic       w_col_ok;

  always_comb begin
    w_row    = 2'd0;
    w_row_ok = 1'b1;
    case (kpr)
      4'b1110: w_row = 2'd0;
      4'b1101: w_row = 2'd1;
      4'b1011: w_row = 2'd2;
      4'b0111: w_row = 2'd3;
      default: w_row_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_col    = 2'd0;
    w_col_ok = 1'b1;
    case (kpc)
      4'b1110: w_col = 2'd0;
      4'b1101: w_col = 2'd1;
      4'b1011: w_col = 2'd2;
      4'b0111: w_col = 2'd3;
      default: w_col_ok = 1'b0;
    endcase
  end

  // Index {row, col}; row 0 / col 0 is the bottom-right key 'd'.
  always_comb begin
    kphit = w_row_ok && w_col_ok;
    code  = 4'h0;
    case ({w_row, w_col})
      4'h0: code = 4'hD;
      4'h1: code = 4'hF;
      4'h2: code = 4'h0;
      4'h3: code = 4'hE;
      4'h4: code = 4'hC;
      4'h5: code = 4'h9;
      4'h6: code = 4'h8;
      4'h7: code = 4'h7;
      4'h8: code = 4'hB;
      4'h9: code = 4'h6;
      4'hA: code = 4'h5;
      4'hB: code = 4'h4;
      4'hC: code = 4'hA;
      4'hD: code = 4'h3;
      4'hE: code = 4'h2;
      4'hF: code = 4'h1;
      default: code = 4'h0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan keypad controller: synchronises rows, debounces per dwell tick,
// reports one key code per press through a level valid / ack handshake.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  input  logic       key_ack,
  output logic       key_valid,
  output logic [3:0] key_num,
  output logic       key_held,
  output logic       overrun
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);

  logic [3:0]       r_kpr_s1;
  logic [3:0]       r_kpr_s2;
  logic [DIV_W-1:0] r_dwell;
  kp_state_t        r_state;
  logic [3:0]       r_kpc;
  logic [3:0]       r_row_l;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic             r_key_valid;
  logic [3:0]       r_key_num;
  logic             r_overrun;

  kp_state_t        w_state_nxt;
  logic [3:0]       w_kpc_nxt;
  logic [3:0]       w_row_l_nxt;
  logic [CNT_W-1:0] w_deb_nxt;
  logic [CNT_W-1:0] w_rel_nxt;
  logic             w_valid_nxt;
  logic [3:0]       w_num_nxt;
  logic             w_ovr_nxt;
  logic             w_tick;
  logic             w_kphit;
  logic [3:0]       w_code;
  logic             w_match;
  logic             w_accept;

  kpdecode u_kpdecode (
    .kpr   (r_kpr_s2),
    .kpc   (r_kpc),
    .kphit (w_kphit),
    .code  (w_code)
  );

  assign w_tick = (r_dwell == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_kpr_s1    <= KP_IDLE;
      r_kpr_s2    <= KP_IDLE;
      r_dwell     <= '0;
      r_state     <= SCAN;
      r_kpc       <= COL_FIRST;
      r_row_l     <= KP_IDLE;
      r_deb_cnt   <= '0;
      r_rel_cnt   <= '0;
      r_key_valid <= 1'b0;
      r_key_num   <= 4'h0;
      r_overrun   <= 1'b0;
    end else begin
      r_kpr_s1    <= kpr;
      r_kpr_s2    <= r_kpr_s1;
      r_dwell     <= w_tick ? '0 : r_dwell + 1'b1;
      r_state     <= w_state_nxt;
      r_kpc       <= w_kpc_nxt;
      r_row_l     <= w_row_l_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_rel_cnt   <= w_rel_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_num   <= w_num_nxt;
      r_overrun   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_kpc_nxt   = r_kpc;
    w_row_l_nxt = r_row_l;
    w_deb_nxt   = r_deb_cnt;
    w_rel_nxt   = r_rel_cnt;
    w_accept    = 1'b0;
    w_match     = w_kphit && (r_kpr_s2 == r_row_l);
    if (w_tick) begin
      case (r_state)
        SCAN: begin
          if (w_kphit) begin
            w_row_l_nxt = r_kpr_s2;
            w_deb_nxt   = CNT_W'(1);
            if (CNT_LAST == '0) begin
              w_accept    = 1'b1;
              w_rel_nxt   = '0;
              w_state_nxt = HELD;
            end else begin
              w_state_nxt = DEBOUNCE;
            end
          end else begin
            w_kpc_nxt = rotate_col(r_kpc);
          end
        end
        DEBOUNCE: begin
          if (!w_match) begin
            w_state_nxt = SCAN;
            w_kpc_nxt   = rotate_col(r_kpc);
          end else if (r_deb_cnt == CNT_LAST) begin
            w_accept    = 1'b1;
            w_rel_nxt   = '0;
            w_state_nxt = HELD;
          end else begin
            w_deb_nxt = r_deb_cnt + 1'b1;
          end
        end
        HELD: begin
          // Any non-idle sample restarts the release count.
          if (r_kpr_s2 != KP_IDLE) begin
            w_rel_nxt = '0;
          end else if (r_rel_cnt == CNT_LAST) begin
            w_rel_nxt   = '0;
            w_state_nxt = SCAN;
            w_kpc_nxt   = rotate_col(r_kpc);
          end else begin
            w_rel_nxt = r_rel_cnt + 1'b1;
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  // An ack on the accept edge frees the slot, so the new key lands without overrun.
  always_comb begin
    w_valid_nxt = r_key_valid;
    w_num_nxt   = r_key_num;
    w_ovr_nxt   = r_overrun;
    if (w_accept) begin
      w_valid_nxt = 1'b1;
      if (r_key_valid && !key_ack) begin
        w_ovr_nxt = 1'b1;
      end else begin
        w_num_nxt = w_code;
        w_ovr_nxt = 1'b0;
      end
    end else if (key_ack) begin
      w_valid_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end
  end

  assign kpc       = r_kpc;
  assign key_valid = r_key_valid;
  assign key_num   = r_key_num;
  assign key_held  = (r_state == HELD);
  assign overrun   = r_overrun;

endmodule
